// File: rtl/gpif_counter_source.sv
// gpif_counter_source
//   Counter data source for the FX3 GPIF II slave-FIFO port. It generates
//   up, down or walking-one words on DQ and drives the write strobe itself.
//   Output is throttled by the FX3 full flag. Data is framed into bursts of
//   BURST_LEN words, each closed by a PKTEND_n pulse and followed by an
//   idle gap.
//
// Ports
//   i_pclk      sole clock, rising edge
//   i_reset_n   synchronous active-low reset
//   i_enable    run request, sampled every cycle
//   i_mode      00 up, 01 down, 10 walking-one, 11 treated as up
//   i_full_n    FX3 full/watermark flag, low = stop writing
//   o_wr_n      write strobe, active low, registered
//   o_pktend_n  packet-end strobe, active low, registered
//   o_dq        write data, registered, valid while o_wr_n is low
//   o_led       top 8 bits of the running count, zero-padded
module gpif_counter_source #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int STEP       = 1,
  parameter int BURST_LEN  = 1024,
  parameter int IDLE_GAP   = 4
) (
  input  logic                  i_pclk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [1:0]            i_mode,
  input  logic                  i_full_n,
  output logic                  o_wr_n,
  output logic                  o_pktend_n,
  output logic [DATA_WIDTH-1:0] o_dq,
  output logic [7:0]            o_led
);

  // The word counter only needs to reach BURST_LEN-1; the increment on the
  // last word may wrap because PKTEND clears it on the next cycle.
  localparam int WC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [WC_W-1:0]      WC_LAST  = WC_W'((BURST_LEN > 0) ? BURST_LEN - 1 : 0);
  localparam logic [7:0]           GAP_LAST = 8'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] STEP_C   = CNT_WIDTH'(STEP);
  localparam logic [CNT_WIDTH-1:0] ONE_C    = CNT_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_STALL, S_PKTEND, S_GAP} state_t;

  state_t                r_state, w_state_nx;
  logic [1:0]            r_mode_q;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  w_count_adv;
  logic [WC_W-1:0]       r_word_cnt;
  logic [7:0]            r_gap_cnt;
  logic                  r_wr_n, r_pktend_n;
  logic [DATA_WIDTH-1:0] r_dq;
  logic                  w_wr_n_nx, w_pktend_n_nx;
  logic [DATA_WIDTH-1:0] w_dq_nx;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_last;
  logic                  w_start;

  // Count zero-extended onto DQ; LED shows its top byte.
  generate
    if (CNT_WIDTH < DATA_WIDTH) begin : g_dq_pad
      assign w_word = {{(DATA_WIDTH-CNT_WIDTH){1'b0}}, r_count};
    end else begin : g_dq_full
      assign w_word = r_count;
    end
    if (CNT_WIDTH >= 8) begin : g_led_top
      assign o_led = r_count[CNT_WIDTH-1 -: 8];
    end else begin : g_led_pad
      assign o_led = {{(8-CNT_WIDTH){1'b0}}, r_count};
    end
  endgenerate

  assign w_last  = (BURST_LEN != 0) && (r_word_cnt == WC_LAST);
  assign w_start = i_enable && i_full_n;

  always_comb begin
    case (r_mode_q)
      2'b01:   w_count_adv = r_count - STEP_C;
      // Rotate left across CNT_WIDTH bits; written with shifts so a 1-bit
      // counter elaborates too.
      2'b10:   w_count_adv = (r_count << 1) | (r_count >> (CNT_WIDTH-1));
      default: w_count_adv = r_count + STEP_C;
    endcase
  end

  // State register
  always_ff @(posedge i_pclk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nx;
  end

  // Next state. Burst completion outranks both the full flag and a drop
  // of enable, so a finished burst is always committed with PKTEND.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nx = S_WRITE;
      S_WRITE: begin
        if (w_last)         w_state_nx = S_PKTEND;
        else if (!i_enable) w_state_nx = S_IDLE;
        else if (!i_full_n) w_state_nx = S_STALL;
      end
      S_STALL: begin
        if (!i_enable)     w_state_nx = S_IDLE;
        else if (i_full_n) w_state_nx = S_WRITE;
      end
      S_PKTEND: w_state_nx = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:    if (r_gap_cnt == GAP_LAST) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Output decode, registered below so every strobe leaves a flop.
  always_comb begin
    w_wr_n_nx     = 1'b1;
    w_pktend_n_nx = 1'b1;
    w_dq_nx       = r_dq;
    case (r_state)
      S_WRITE: begin
        w_wr_n_nx = 1'b0;
        w_dq_nx   = w_word;
      end
      S_STALL:  w_dq_nx = w_word;
      S_PKTEND: w_pktend_n_nx = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (!i_reset_n) begin
      r_wr_n     <= 1'b1;
      r_pktend_n <= 1'b1;
      r_dq       <= '0;
      r_count    <= '0;
      r_mode_q   <= 2'b00;
      r_word_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_wr_n     <= w_wr_n_nx;
      r_pktend_n <= w_pktend_n_nx;
      r_dq       <= w_dq_nx;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_mode_q <= i_mode;
          // Entering walking-one from another mode reloads the single bit;
          // staying in walking-one keeps rotating from where it was.
          if (i_mode == 2'b10 && r_mode_q != 2'b10) r_count <= ONE_C;
        end
        S_WRITE: begin
          r_count    <= w_count_adv;
          r_word_cnt <= r_word_cnt + 1'b1;
        end
        S_PKTEND: begin
          r_word_cnt <= '0;
          r_gap_cnt  <= '0;
        end
        S_GAP:   r_gap_cnt <= r_gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign o_wr_n     = r_wr_n;
  assign o_pktend_n = r_pktend_n;
  assign o_dq       = r_dq;

endmodule
